// File: rtl/mem_port_arbiter_if.sv
// Fetch/data requester, memory port and status bundle of the memory arbiter.
// master = arbiter side, slave = pipeline/memory environment side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic        if_kill;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        stall_if;
    logic        stall_d;
    logic        err_timeout;

    modport master (
        input  if_req, if_kill, if_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output stall_if, stall_d, err_timeout
    );

    modport slave (
        output if_req, if_kill, if_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  stall_if, stall_d, err_timeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data access via IDLE/BUSY/RESP FSM.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed D-over-IF priority.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WD_EN = (TIMEOUT > 0);

    state_t      r_state, w_n_state;
    owner_t      r_owner, w_n_owner;
    logic        r_mem_req, w_n_mem_req;
    logic        r_mem_we, w_n_mem_we;
    logic [3:0]  r_mem_be, w_n_mem_be;
    logic [31:0] r_mem_addr, w_n_mem_addr;
    logic [31:0] r_mem_wdata, w_n_mem_wdata;
    logic [31:0] r_if_rdata, w_n_if_rdata;
    logic [31:0] r_d_rdata, w_n_d_rdata;
    logic        r_if_ack, w_n_if_ack;
    logic        r_d_ack, w_n_d_ack;
    logic        r_err, w_n_err;
    logic        r_kill, w_n_kill;
    logic [CW-1:0] r_wdog, w_n_wdog;

    logic w_if_elig;
    logic w_d_elig;
    logic w_d_wins;
    logic w_gnt_d;
    logic w_gnt_if;
    logic w_wd_exp;
    logic w_if_ack;

    assign w_if_elig = bus.if_req & ~bus.if_kill;
    assign w_d_elig  = bus.d_req;

`ifdef MEM_ARB_RR_EN
    owner_t r_last;

    // Tie goes to whoever did not win the previous grant.
    assign w_d_wins = (r_last == OWN_IF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= OWN_IF;
        end else if (r_state == S_IDLE && (w_gnt_d || w_gnt_if)) begin
            r_last <= w_gnt_d ? OWN_D : OWN_IF;
        end
    end
`else
    // The access stage holds the older instruction.
    assign w_d_wins = 1'b1;
`endif

    assign w_gnt_d  = w_d_elig & (~w_if_elig | w_d_wins);
    assign w_gnt_if = w_if_elig & ~w_gnt_d;
    assign w_wd_exp = WD_EN && (r_wdog == WD_MAX);

    always_comb begin
        w_n_state     = r_state;
        w_n_owner     = r_owner;
        w_n_mem_req   = r_mem_req;
        w_n_mem_we    = r_mem_we;
        w_n_mem_be    = r_mem_be;
        w_n_mem_addr  = r_mem_addr;
        w_n_mem_wdata = r_mem_wdata;
        w_n_if_rdata  = r_if_rdata;
        w_n_d_rdata   = r_d_rdata;
        w_n_if_ack    = 1'b0;
        w_n_d_ack     = 1'b0;
        w_n_err       = 1'b0;
        w_n_kill      = r_kill;
        w_n_wdog      = r_wdog;
        unique case (r_state)
            S_IDLE: begin
                if (w_gnt_d) begin
                    w_n_owner     = OWN_D;
                    w_n_mem_req   = 1'b1;
                    w_n_mem_we    = bus.d_we;
                    w_n_mem_be    = bus.d_be;
                    w_n_mem_addr  = bus.d_addr;
                    w_n_mem_wdata = bus.d_wdata;
                    w_n_kill      = 1'b0;
                    w_n_wdog      = '0;
                    w_n_state     = S_BUSY;
                end else if (w_gnt_if) begin
                    w_n_owner     = OWN_IF;
                    w_n_mem_req   = 1'b1;
                    w_n_mem_we    = 1'b0;
                    w_n_mem_be    = 4'hF;
                    w_n_mem_addr  = bus.if_addr;
                    w_n_kill      = 1'b0;
                    w_n_wdog      = '0;
                    w_n_state     = S_BUSY;
                end
            end
            S_BUSY: begin
                w_n_wdog = r_wdog + CW'(1);
                if (r_owner == OWN_IF && bus.if_kill) begin
                    w_n_kill = 1'b1;
                end
                // A completion in the expiry cycle beats the abort.
                if (bus.mem_ready) begin
                    w_n_mem_req = 1'b0;
                    w_n_state   = S_RESP;
                    if (r_owner == OWN_IF) begin
                        w_n_if_rdata = bus.mem_rdata;
                        w_n_if_ack   = 1'b1;
                    end else begin
                        w_n_d_rdata = bus.mem_rdata;
                        w_n_d_ack   = 1'b1;
                    end
                end else if (w_wd_exp) begin
                    w_n_mem_req = 1'b0;
                    w_n_err     = 1'b1;
                    w_n_state   = S_RESP;
                    if (r_owner == OWN_IF) begin
                        w_n_if_rdata = '0;
                        w_n_if_ack   = 1'b1;
                    end else begin
                        w_n_d_rdata = '0;
                        w_n_d_ack   = 1'b1;
                    end
                end
            end
            S_RESP: begin
                w_n_state = S_IDLE;
            end
            default: begin
                w_n_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_IF;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_err       <= 1'b0;
            r_kill      <= 1'b0;
            r_wdog      <= '0;
        end else begin
            r_state     <= w_n_state;
            r_owner     <= w_n_owner;
            r_mem_req   <= w_n_mem_req;
            r_mem_we    <= w_n_mem_we;
            r_mem_be    <= w_n_mem_be;
            r_mem_addr  <= w_n_mem_addr;
            r_mem_wdata <= w_n_mem_wdata;
            r_if_rdata  <= w_n_if_rdata;
            r_d_rdata   <= w_n_d_rdata;
            r_if_ack    <= w_n_if_ack;
            r_d_ack     <= w_n_d_ack;
            r_err       <= w_n_err;
            r_kill      <= w_n_kill;
            r_wdog      <= w_n_wdog;
        end
    end

    // A discarded fetch is drained but never acknowledged.
    assign w_if_ack = r_if_ack & ~r_kill & ~bus.if_kill;

    assign bus.if_ack      = w_if_ack;
    assign bus.if_rdata    = w_if_ack ? r_if_rdata : '0;
    assign bus.d_ack       = r_d_ack;
    assign bus.d_rdata     = r_d_ack ? r_d_rdata : '0;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we & r_mem_req;
    assign bus.mem_be      = r_mem_be;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.stall_if    = bus.if_req & ~bus.if_kill & ~w_if_ack;
    assign bus.stall_d     = bus.d_req & ~r_d_ack;
    assign bus.err_timeout = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand sequences for ties, watchdog, kill and reset corner cases.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifr;
        logic        kil;
        logic [31:0] ia;
        logic        dr;
        logic        we;
        logic [31:0] da;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] rd;
        logic        mreq;
        logic        mwe;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic        iak;
        logic [31:0] ird;
        logic        dak;
        logic [31:0] drd;
        logic        sif;
        logic        sd;
    } vec_t;

    vec_t tv [25];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.if_req    = 1'b0;
        bus.if_kill   = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_be      = 4'b0011;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic apply(input vec_t v);
        bus.if_req    = v.ifr;
        bus.if_kill   = v.kil;
        bus.if_addr   = v.ia;
        bus.d_req     = v.dr;
        bus.d_we      = v.we;
        bus.d_addr    = v.da;
        bus.d_wdata   = v.wd;
        bus.mem_ready = v.rdy;
        bus.mem_rdata = v.rd;
    endtask

    task automatic check_row(input int i, input vec_t v);
        string p;
        p = $sformatf("row%0d", i);
        chk({p, ".mem_req"}, bus.mem_req, v.mreq);
        chk({p, ".mem_we"}, bus.mem_we, v.mwe);
        chk({p, ".mem_addr"}, bus.mem_addr, v.ma);
        chk({p, ".mem_wdata"}, bus.mem_wdata, v.mwd);
        chk({p, ".if_ack"}, bus.if_ack, v.iak);
        chk({p, ".if_rdata"}, bus.if_rdata, v.ird);
        chk({p, ".d_ack"}, bus.d_ack, v.dak);
        chk({p, ".d_rdata"}, bus.d_rdata, v.drd);
        chk({p, ".stall_if"}, bus.stall_if, v.sif);
        chk({p, ".stall_d"}, bus.stall_d, v.sd);
        chk({p, ".err"}, bus.err_timeout, 1'b0);
    endtask

    // From IDLE (requests already driven): expect grant of addr a,
    // complete in one BUSY cycle, expect the matching ack in RESP.
    task automatic gc(input logic [31:0] a, input logic is_d,
                      input string nm);
        step();
        chk({nm, ".mem_req"}, bus.mem_req, 1'b1);
        chk({nm, ".addr"}, bus.mem_addr, a);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = a ^ 32'h0000_F0F0;
        step();
        bus.mem_ready = 1'b0;
        chk({nm, ".d_ack"}, bus.d_ack, is_d);
        chk({nm, ".if_ack"}, bus.if_ack, !is_d);
    endtask

    initial begin
        // ifr kil ia | dr we da wd | rdy rd | mreq mwe ma mwd | iak ird | dak drd | sif sd
        tv[0]  = '{1,0,32'h100, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 1,0};
        tv[1]  = '{1,0,32'h100, 0,0,0,0, 1,32'h00500093, 1,0,32'h100,0, 0,0, 0,0, 1,0};
        tv[2]  = '{1,0,32'h100, 0,0,0,0, 1,32'hDEAD0000, 0,0,32'h100,0, 1,32'h00500093, 0,0, 0,0};
        tv[3]  = '{0,0,0, 0,0,0,0, 1,0, 0,0,32'h100,0, 0,0, 0,0, 0,0};
        tv[4]  = '{0,0,0, 1,1,32'h2000,32'hDEADBEEF, 0,0, 0,0,32'h100,0, 0,0, 0,0, 0,1};
        tv[5]  = '{0,0,0, 1,1,32'h2000,32'hDEADBEEF, 0,0, 1,1,32'h2000,32'hDEADBEEF, 0,0, 0,0, 0,1};
        tv[6]  = '{0,0,0, 1,1,32'h2000,32'hDEADBEEF, 0,0, 1,1,32'h2000,32'hDEADBEEF, 0,0, 0,0, 0,1};
        tv[7]  = '{0,0,0, 1,1,32'h2000,32'hDEADBEEF, 0,0, 1,1,32'h2000,32'hDEADBEEF, 0,0, 0,0, 0,1};
        tv[8]  = '{0,0,0, 1,1,32'h2000,32'hDEADBEEF, 1,32'h11110000, 1,1,32'h2000,32'hDEADBEEF, 0,0, 0,0, 0,1};
        tv[9]  = '{0,0,0, 1,1,32'h2000,32'hDEADBEEF, 0,0, 0,0,32'h2000,32'hDEADBEEF, 0,0, 1,32'h11110000, 0,0};
        tv[10] = '{0,0,0, 0,0,0,0, 0,0, 0,0,32'h2000,32'hDEADBEEF, 0,0, 0,0, 0,0};
        tv[11] = '{1,0,32'h200, 0,0,0,0, 0,0, 0,0,32'h2000,32'hDEADBEEF, 0,0, 0,0, 1,0};
        tv[12] = '{1,1,32'h200, 0,0,0,0, 0,0, 1,0,32'h200,32'hDEADBEEF, 0,0, 0,0, 0,0};
        tv[13] = '{0,0,0, 1,0,32'h300,0, 1,32'h1234, 1,0,32'h200,32'hDEADBEEF, 0,0, 0,0, 0,1};
        tv[14] = '{0,0,0, 1,0,32'h300,0, 0,0, 0,0,32'h200,32'hDEADBEEF, 0,0, 0,0, 0,1};
        tv[15] = '{0,0,0, 1,0,32'h300,0, 0,0, 0,0,32'h200,32'hDEADBEEF, 0,0, 0,0, 0,1};
        tv[16] = '{0,0,0, 1,0,32'h300,0, 1,32'hAA55, 1,0,32'h300,0, 0,0, 0,0, 0,1};
        tv[17] = '{0,0,0, 1,0,32'h300,0, 0,0, 0,0,32'h300,0, 0,0, 1,32'hAA55, 0,0};
        tv[18] = '{1,1,32'h500, 1,0,32'h400,0, 0,0, 0,0,32'h300,0, 0,0, 0,0, 0,1};
        tv[19] = '{1,0,32'h500, 1,0,32'h400,0, 1,32'h77, 1,0,32'h400,0, 0,0, 0,0, 1,1};
        tv[20] = '{1,0,32'h500, 1,0,32'h400,0, 0,0, 0,0,32'h400,0, 0,0, 1,32'h77, 1,0};
        tv[21] = '{1,0,32'h500, 0,0,0,0, 0,0, 0,0,32'h400,0, 0,0, 0,0, 1,0};
        tv[22] = '{1,0,32'h500, 0,0,0,0, 1,32'h99, 1,0,32'h500,0, 0,0, 0,0, 1,0};
        tv[23] = '{1,0,32'h500, 0,0,0,0, 0,0, 0,0,32'h500,0, 1,32'h99, 0,0, 0,0};
        tv[24] = '{0,0,0, 0,0,0,0, 0,0, 0,0,32'h500,0, 0,0, 0,0, 0,0};

        rst = 1'b1;
        clear_in();
        step();
        step();
        chk("rst.mem_req", bus.mem_req, 1'b0);
        chk("rst.mem_we", bus.mem_we, 1'b0);
        chk("rst.mem_be", bus.mem_be, 4'h0);
        chk("rst.mem_addr", bus.mem_addr, 32'h0);
        chk("rst.mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst.acks", {bus.if_ack, bus.d_ack}, 2'b00);
        chk("rst.err", bus.err_timeout, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            apply(tv[i]);
            #3;
            check_row(i, tv[i]);
            step();
        end
        clear_in();

        // Ties: D first; single pending IF next; D re-request decides mode.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h600;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h700;
        gc(32'h700, 1'b1, "tie1");
        step();
        bus.d_req = 1'b0;
        gc(32'h600, 1'b0, "tie2");
        step();
        bus.d_req = 1'b1;
        gc(32'h700, 1'b1, "tie3");
        step();
        bus.d_addr = 32'h780;
`ifdef MEM_ARB_RR_EN
        gc(32'h600, 1'b0, "tie4");
        step();
        bus.if_req = 1'b0;
        gc(32'h780, 1'b1, "tie5");
`else
        gc(32'h780, 1'b1, "tie4");
        step();
        bus.d_req = 1'b0;
        gc(32'h600, 1'b0, "tie5");
`endif
        step();
        clear_in();

        // Watchdog abort after exactly 8 BUSY cycles.
        bus.d_req     = 1'b1;
        bus.d_addr    = 32'h800;
        bus.mem_rdata = 32'hFFFF_FFFF;
        step();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wd.busy%0d.mem_req", i), bus.mem_req, 1'b1);
            chk($sformatf("wd.busy%0d.err", i), bus.err_timeout, 1'b0);
            step();
        end
        chk("wd.resp.mem_req", bus.mem_req, 1'b0);
        chk("wd.resp.err", bus.err_timeout, 1'b1);
        chk("wd.resp.d_ack", bus.d_ack, 1'b1);
        chk("wd.resp.d_rdata", bus.d_rdata, 32'h0);
        step();
        bus.d_addr = 32'h900;
        chk("wd.idle.err", bus.err_timeout, 1'b0);
        chk("wd.idle.d_ack", bus.d_ack, 1'b0);

        // mem_ready in the expiry cycle wins over the abort.
        step();
        for (int i = 0; i < 7; i++) step();
        chk("wdr.busy8.mem_req", bus.mem_req, 1'b1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5A5A;
        step();
        bus.mem_ready = 1'b0;
        chk("wdr.err", bus.err_timeout, 1'b0);
        chk("wdr.d_ack", bus.d_ack, 1'b1);
        chk("wdr.d_rdata", bus.d_rdata, 32'h5A5A);
        step();
        clear_in();

        // Reset two cycles into BUSY, then a normal transaction.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'hA00;
        bus.d_wdata = 32'h1234_5678;
        step();
        chk("rb.mem_be", bus.mem_be, 4'b0011);
        chk("rb.mem_we", bus.mem_we, 1'b1);
        step();
        chk("rb.busy2.mem_req", bus.mem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("rb.rst.mem_req", bus.mem_req, 1'b0);
        chk("rb.rst.mem_we", bus.mem_we, 1'b0);
        chk("rb.rst.mem_addr", bus.mem_addr, 32'h0);
        chk("rb.rst.acks", {bus.if_ack, bus.d_ack}, 2'b00);
        step();
        rst = 1'b0;
        step();
        chk("rb.post.mem_req", bus.mem_req, 1'b1);
        chk("rb.post.mem_addr", bus.mem_addr, 32'hA00);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        chk("rb.post.d_ack", bus.d_ack, 1'b1);
        step();
        clear_in();

        // if_kill arriving in RESP suppresses the ack combinationally.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'hB00;
        step();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h42;
        step();
        bus.mem_ready = 1'b0;
        chk("kr.if_ack", bus.if_ack, 1'b1);
        chk("kr.if_rdata", bus.if_rdata, 32'h42);
        bus.if_kill = 1'b1;
        #1;
        chk("kr.kill.if_ack", bus.if_ack, 1'b0);
        chk("kr.kill.if_rdata", bus.if_rdata, 32'h0);
        chk("kr.kill.stall_if", bus.stall_if, 1'b0);
        step();
        clear_in();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
